// File: rtl/scoreboard_char_buf_pkg.sv
// Shared constants, state encoding and helpers for the multi-player score text buffer.
package scoreboard_pkg;

  localparam logic [6:0] CH_SPACE   = 7'h20;
  localparam logic [6:0] CH_COLON   = 7'h3A;
  localparam logic [6:0] CH_GREATER = 7'h3E;
  localparam logic [6:0] CH_LESS    = 7'h3C;
  localparam logic [6:0] CH_NUM0    = 7'h30;
  localparam logic [6:0] CH_S       = 7'h53;
  localparam logic [6:0] CH_C       = 7'h43;
  localparam logic [6:0] CH_O       = 7'h4F;
  localparam logic [6:0] CH_R       = 7'h52;
  localparam logic [6:0] CH_E       = 7'h45;
  localparam logic [6:0] CH_P       = 7'h50;
  localparam logic [6:0] CH_LC_L    = 7'h6C;
  localparam logic [6:0] CH_LC_A    = 7'h61;
  localparam logic [6:0] CH_LC_Y    = 7'h79;
  localparam logic [6:0] CH_LC_E    = 7'h65;
  localparam logic [6:0] CH_LC_R    = 7'h72;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [6:0] HEADER [16] = '{
    CH_GREATER, CH_GREATER, CH_GREATER, CH_GREATER, CH_GREATER,
    CH_S, CH_C, CH_O, CH_R, CH_E, CH_COLON,
    CH_LESS, CH_LESS, CH_LESS, CH_LESS, CH_LESS
  };

  localparam logic [6:0] PLAYER_STR [6] = '{
    CH_P, CH_LC_L, CH_LC_A, CH_LC_Y, CH_LC_E, CH_LC_R
  };

  function automatic int unsigned max_score(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/scoreboard_char_buf_if.sv
// Score capture and character lookup bus between the host/renderer and the score buffer.
interface scoreboard_char_buf_if #(
  parameter int PLAYERS = 3,
  parameter int SCORE_W = 20
);
  logic [PLAYERS*SCORE_W-1:0] score_bin;
  logic                       score_valid;
  logic [7:0]                 char_xy;
  logic [6:0]                 char_code;
  logic                       busy;

  modport master (output score_bin, score_valid, char_xy, input char_code, busy);
  modport slave  (input score_bin, score_valid, char_xy, output char_code, busy);
endinterface

// File: rtl/scoreboard_char_buf_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3-then-shift step per cycle after start.
module bin2bcd_seq #(
  parameter int SCORE_W = 20,
  parameter int DIGITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    load_val,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(SCORE_W + 1);
  localparam int BW = 4 * DIGITS;

  logic [SCORE_W-1:0] sh_q, sh_d;
  logic [BW-1:0]      acc_q, acc_d, adj;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    adj   = acc_q;
    sh_d  = sh_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    if (start) begin
      sh_d  = load_val;
      acc_d = '0;
      cnt_d = CW'(SCORE_W);
    end else if (cnt_q != '0) begin
      // Carry out of the top digit is dropped; the caller saturates instead.
      acc_d = {adj[BW-2:0], sh_q[SCORE_W-1]};
      sh_d  = {sh_q[SCORE_W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1)) && !start;
  assign bcd  = acc_q;

endmodule

// File: rtl/scoreboard_char_buf.sv
// Multi-player score text buffer: captures binary scores, converts to BCD, serves 16x16 text codes.
module scoreboard_char_buf
  import scoreboard_pkg::*;
#(
  parameter int PLAYERS  = 3,
  parameter int DIGITS   = 6,
  parameter int SCORE_W  = 20,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  scoreboard_char_buf_if.slave  bus
);
  localparam int          PW   = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int          BW   = 4 * DIGITS;
  localparam int unsigned MAXV = max_score(DIGITS);

  state_e                     state_q, state_d;
  logic [PLAYERS*SCORE_W-1:0] cap_q, cap_d;
  logic [PW-1:0]              p_q, p_d;
  logic                       sat_q, sat_d;
  logic [BW-1:0]              shadow_q [PLAYERS];
  logic [BW-1:0]              disp_q   [PLAYERS];
  logic [SCORE_W-1:0]         cur_val;
  logic                       cvt_start, cvt_done;
  logic [BW-1:0]              cvt_bcd;
  logic [6:0]                 char_q, char_d;

  assign cur_val = cap_q[int'(p_q)*SCORE_W +: SCORE_W];

  bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (cvt_start),
    .load_val (cur_val),
    .done     (cvt_done),
    .bcd      (cvt_bcd)
  );

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    p_d       = p_q;
    sat_d     = sat_q;
    cvt_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.score_valid) begin
        cap_d   = bus.score_bin;
        p_d     = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cvt_start = 1'b1;
        sat_d     = (32'(cur_val) > MAXV);
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: if (cvt_done) state_d = ST_STORE;
      ST_STORE: begin
        if (p_q == PW'(PLAYERS - 1)) state_d = ST_COMMIT;
        else begin
          p_d     = p_q + PW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      p_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      p_q     <= p_d;
      sat_q   <= sat_d;
    end
  end

  // Shadow slots fill one player at a time; the display only changes on COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PLAYERS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      if (state_q == ST_STORE) shadow_q[p_q] <= sat_q ? {DIGITS{4'h9}} : cvt_bcd;
      if (state_q == ST_COMMIT) disp_q <= shadow_q;
    end
  end

  logic [3:0]    row, col, dig;
  logic [BW-1:0] prow;
  logic          lead;

  always_comb begin
    row    = bus.char_xy[7:4];
    col    = bus.char_xy[3:0];
    char_d = CH_SPACE;
    prow   = '0;
    dig    = '0;
    lead   = 1'b1;
    if (row == 4'd0) begin
      char_d = HEADER[col];
    end else if (int'(row) <= PLAYERS) begin
      prow = disp_q[PW'(row - 4'd1)];
      if (col < 4'd6)       char_d = PLAYER_STR[col[2:0]];
      else if (col == 4'd6) char_d = CH_NUM0 + {3'b000, row};
      else if (col == 4'd7) char_d = CH_COLON;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        dig = prow[BW-4-4*i +: 4];
        if (int'(col) == 16 - DIGITS + int'(i))
          char_d = (LZ_BLANK && lead && dig == 4'd0 && int'(i) != DIGITS - 1) ? CH_SPACE : {3'b011, dig};
        if (dig != 4'd0) lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_q <= CH_SPACE;
    else     char_q <= char_d;
  end

  assign bus.char_code = char_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scoreboard_char_buf.sv
// Directed bench for scoreboard_char_buf: plain and leading-zero-blanking instances side by side.
module tb_scoreboard_char_buf;
  localparam int PLAYERS = 3;
  localparam int SCORE_W = 20;
  localparam int DIGITS  = 6;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  scoreboard_char_buf_if #(.PLAYERS(PLAYERS), .SCORE_W(SCORE_W)) bus ();
  scoreboard_char_buf_if #(.PLAYERS(PLAYERS), .SCORE_W(SCORE_W)) bus_lz ();

  scoreboard_char_buf #(.PLAYERS(PLAYERS), .DIGITS(DIGITS), .SCORE_W(SCORE_W), .LZ_BLANK(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  scoreboard_char_buf #(.PLAYERS(PLAYERS), .DIGITS(DIGITS), .SCORE_W(SCORE_W), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .bus(bus_lz)
  );

  task automatic drive_scores(input logic [19:0] p1, input logic [19:0] p2, input logic [19:0] p3,
                              input logic v);
    bus.score_bin      = {p3, p2, p1};
    bus_lz.score_bin   = {p3, p2, p1};
    bus.score_valid    = v;
    bus_lz.score_valid = v;
  endtask

  task automatic look(input logic [7:0] xy, output logic [6:0] c, output logic [6:0] c_lz);
    @(negedge clk);
    bus.char_xy    = xy;
    bus_lz.char_xy = xy;
    @(posedge clk);
    #1;
    c    = bus.char_code;
    c_lz = bus_lz.char_code;
  endtask

  task automatic run_conv(input logic [19:0] p1, input logic [19:0] p2, input logic [19:0] p3,
                          input int inject_at, output int n);
    @(negedge clk);
    drive_scores(p1, p2, p3, 1'b1);
    @(negedge clk);
    bus.score_valid    = 1'b0;
    bus_lz.score_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (inject_at != 0 && n == inject_at) drive_scores(20'd42, 20'd42, 20'd42, 1'b1);
      else if (inject_at != 0 && n == inject_at + 1) begin
        bus.score_valid    = 1'b0;
        bus_lz.score_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] xy [5];
    logic [6:0] e  [5];
    logic [6:0] c, cl;
    xy = '{8'h00, 8'h05, 8'h1F, 8'h16, 8'h40};
    e  = '{7'h3E, 7'h53, 7'h30, 7'h31, 7'h20};
    rst = 1'b1;
    drive_scores('0, '0, '0, 1'b0);
    bus.char_xy    = 8'h00;
    bus_lz.char_xy = 8'h00;
    #12;
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", bus.busy); failures++; end
    checks++;
    if (bus.char_code !== 7'h20) begin $display("FAIL reset_code got=%h exp=20", bus.char_code); failures++; end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look(xy[i], c, cl);
      checks++;
      if (c !== e[i]) begin $display("FAIL reset_lookup xy=%h got=%h exp=%h", xy[i], c, e[i]); failures++; end
    end
    look(8'h1F, c, cl);
    checks++;
    if (cl !== 7'h30) begin $display("FAIL reset_lz_1F got=%h exp=30", cl); failures++; end
    look(8'h1E, c, cl);
    checks++;
    if (cl !== 7'h20) begin $display("FAIL reset_lz_1E got=%h exp=20", cl); failures++; end
  endtask

  task automatic test_basic;
    logic [6:0] e1 [6];
    logic [6:0] e3 [6];
    logic [6:0] e3l [6];
    logic [6:0] c, cl;
    int n;
    e1  = '{7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36};
    e3  = '{7'h30, 7'h30, 7'h30, 7'h39, 7'h39, 7'h39};
    e3l = '{7'h20, 7'h20, 7'h20, 7'h39, 7'h39, 7'h39};
    run_conv(20'd123456, 20'd0, 20'd999, 0, n);
    checks++;
    if (n != 67) begin $display("FAIL basic_busy_len got=%0d exp=67", n); failures++; end
    for (int i = 0; i < 6; i++) begin
      look(8'(8'h1A + i), c, cl);
      checks++;
      if (c !== e1[i]) begin $display("FAIL basic_p1 col=%0d got=%h exp=%h", 10 + i, c, e1[i]); failures++; end
      look(8'(8'h2A + i), c, cl);
      checks++;
      if (c !== 7'h30) begin $display("FAIL basic_p2 col=%0d got=%h exp=30", 10 + i, c); failures++; end
      look(8'(8'h3A + i), c, cl);
      checks++;
      if (c !== e3[i]) begin $display("FAIL basic_p3 col=%0d got=%h exp=%h", 10 + i, c, e3[i]); failures++; end
      checks++;
      if (cl !== e3l[i]) begin $display("FAIL basic_p3_lz col=%0d got=%h exp=%h", 10 + i, cl, e3l[i]); failures++; end
    end
  endtask

  task automatic test_saturation;
    logic [6:0] e2 [6];
    logic [6:0] c, cl;
    int n;
    e2 = '{7'h30, 7'h30, 7'h35, 7'h30, 7'h30, 7'h30};
    run_conv(20'd1048575, 20'd5000, 20'd1, 0, n);
    checks++;
    if (n != 67) begin $display("FAIL sat_busy_len got=%0d exp=67", n); failures++; end
    for (int i = 0; i < 6; i++) begin
      look(8'(8'h1A + i), c, cl);
      checks++;
      if (c !== 7'h39) begin $display("FAIL sat_p1 col=%0d got=%h exp=39", 10 + i, c); failures++; end
      look(8'(8'h2A + i), c, cl);
      checks++;
      if (c !== e2[i]) begin $display("FAIL sat_p2 col=%0d got=%h exp=%h", 10 + i, c, e2[i]); failures++; end
    end
  endtask

  task automatic test_ignored;
    logic [6:0] e1 [6];
    logic [6:0] c, cl;
    int n;
    e1 = '{7'h36, 7'h35, 7'h34, 7'h33, 7'h32, 7'h31};
    run_conv(20'd654321, 20'd100, 20'd0, 10, n);
    checks++;
    if (n != 67) begin $display("FAIL ign_busy_len got=%0d exp=67", n); failures++; end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL ign_restarted busy got=%b exp=0", bus.busy); failures++; end
    for (int i = 0; i < 6; i++) begin
      look(8'(8'h1A + i), c, cl);
      checks++;
      if (c !== e1[i]) begin $display("FAIL ign_p1 col=%0d got=%h exp=%h", 10 + i, c, e1[i]); failures++; end
    end
    look(8'h2D, c, cl);
    checks++;
    if (c !== 7'h31) begin $display("FAIL ign_p2_2D got=%h exp=31", c); failures++; end
  endtask

  task automatic test_reset_mid;
    logic [6:0] c, cl;
    int n;
    @(negedge clk);
    drive_scores(20'd111111, 20'd222222, 20'd333333, 1'b1);
    @(negedge clk);
    bus.score_valid    = 1'b0;
    bus_lz.score_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      n++;
      if (n < 30) @(negedge clk);
    end
    checks++;
    if (n != 30) begin $display("FAIL mid_reached got=%0d exp=30", n); failures++; end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL mid_busy got=%b exp=0", bus.busy); failures++; end
    checks++;
    if (bus.char_code !== 7'h20) begin $display("FAIL mid_code got=%h exp=20", bus.char_code); failures++; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    look(8'h1F, c, cl);
    checks++;
    if (c !== 7'h30) begin $display("FAIL mid_1F got=%h exp=30", c); failures++; end
    look(8'h1A, c, cl);
    checks++;
    if (c !== 7'h30) begin $display("FAIL mid_1A got=%h exp=30", c); failures++; end
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL mid_idle busy got=%b exp=0", bus.busy); failures++; end
  endtask

  task automatic test_lz_blank;
    logic [6:0] c, cl;
    int n;
    run_conv(20'd7, 20'd0, 20'd0, 0, n);
    checks++;
    if (n != 67) begin $display("FAIL lz_busy_len got=%0d exp=67", n); failures++; end
    for (int i = 0; i < 5; i++) begin
      look(8'(8'h1A + i), c, cl);
      checks++;
      if (cl !== 7'h20) begin $display("FAIL lz_p1 col=%0d got=%h exp=20", 10 + i, cl); failures++; end
      checks++;
      if (c !== 7'h30) begin $display("FAIL nolz_p1 col=%0d got=%h exp=30", 10 + i, c); failures++; end
    end
    look(8'h1F, c, cl);
    checks++;
    if (cl !== 7'h37) begin $display("FAIL lz_1F got=%h exp=37", cl); failures++; end
    checks++;
    if (c !== 7'h37) begin $display("FAIL nolz_1F got=%h exp=37", c); failures++; end
    look(8'h2F, c, cl);
    checks++;
    if (cl !== 7'h30) begin $display("FAIL lz_2F got=%h exp=30", cl); failures++; end
    look(8'h2E, c, cl);
    checks++;
    if (cl !== 7'h20) begin $display("FAIL lz_2E got=%h exp=20", cl); failures++; end
    look(8'h27, c, cl);
    checks++;
    if (c !== 7'h3A) begin $display("FAIL row2_colon got=%h exp=3a", c); failures++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_ignored();
    test_reset_mid();
    test_lz_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboard_char_buf.md
# scoreboard_char_buf

Registered, multi-player successor to the 16x16 score text ROM. It captures one binary score per player and converts each to BCD with a sequential double-dabble engine. The converted digits are committed atomically to a display register set. The block serves 7-bit character codes to the 16x16 text renderer, one cycle after each `char_xy` lookup.

## Interface
- `PLAYERS`, default 3: number of player rows, legal range 1..9.
- `DIGITS`, default 6: displayed digits per score, legal range 1..6.
- `SCORE_W`, default 20: binary score width per player, legal range 4..24.
- `LZ_BLANK`, default 0: when 1, leading zeros are shown as SPACE.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `score_bin` in PLAYERS*SCORE_W: packed binary scores; player 1 occupies bits [SCORE_W-1:0].
- `score_valid` in 1: single-cycle capture request.
- `char_xy` in 8: [7:4] is the row, [3:0] is the column.
- `char_code` out 7: registered character code.
- `busy` out 1: high while a conversion is in progress.

## Operation
- **Screen map:**
  - Row 0: `>>>>>SCORE:<<<<<`.
  - Row r, for 1 ≤ r ≤ PLAYERS: `Player`, then digit r (7'h30+r), then `:`.
  - Columns 8..(15-DIGITS) of a player row are SPACE.
  - Columns (16-DIGITS)..15 hold the player's digits, most significant first.
  - All other rows and columns are SPACE (7'h20).
- **Digit code:** {3'b011, bcd}.
- **Leading-zero blanking:** when LZ_BLANK=1, a zero digit is SPACE if every more-significant digit is also zero. Column 15 is never blanked.
- **FSM states:** IDLE, LOAD, SHIFT, STORE, COMMIT.
  - IDLE, score_valid=1: capture all of `score_bin` into the capture register, set player index p=0, go to LOAD.
  - LOAD: load player p's value into the shifter and clear the BCD accumulator. Set `sat` if the value > 10^DIGITS-1. Go to SHIFT.
  - SHIFT: run exactly SCORE_W add-3-then-shift iterations, one per cycle, then go to STORE.
  - STORE: write the BCD result into shadow slot p; write all 9s if `sat`. If p = PLAYERS-1, go to COMMIT; otherwise increment p and go to LOAD.
  - COMMIT: copy all shadow slots into the display registers in one cycle, then go to IDLE.
- **Accumulator width:** 4*DIGITS bits. Carries out of the top digit are discarded; saturation covers that case.
- **score_valid outside IDLE:** ignored. There is no queue and no latch.
- **Display during conversion:** the display registers keep their previous values until COMMIT, so a partially updated score is never shown.

## Timing
- **Lookup latency:** `char_code` is valid 1 cycle after `char_xy` is applied. The lookup path runs every cycle, independent of the FSM.
- **busy:**
  - Rises the cycle after score_valid is accepted.
  - Stays high for PLAYERS*(SCORE_W+2)+1 cycles; that is 67 cycles at the defaults.
  - Falls in the cycle after COMMIT.
- **New digits:** visible on `char_code` for lookups issued from the first cycle after COMMIT.
- **score_valid on the cycle busy falls:** accepted, because the FSM is already in IDLE.
- **Reset values:** `char_code` = 7'h20, `busy` = 0, FSM = IDLE. Display, shadow and capture registers all reset to 0, so each score shows as `000000`, or as `     0` with LZ_BLANK=1.
- **Reset mid-conversion:** aborts immediately. Shadow contents are discarded and the display returns to zeros.
- **Score = 0:** converts in the normal cycle count; there is no early exit.

## Structure
- **Package `scoreboard_pkg`:**
  - Character constants: SPACE, COLON, GREATER, LESS, NUM0, and the letters used.
  - FSM state enum.
  - Header string as a 16-entry constant.
  - Function computing 10^DIGITS-1.
- **Sub-module `bin2bcd_seq`:**
  - Parameters SCORE_W and DIGITS.
  - Ports: start, a shifter load value, done, and bcd.
  - Contains the SHIFT iteration counter.
- **Top level:** capture, shadow and display registers, the player index, and the registered character lookup mux.

## Test plan
1. **Reset state:** defaults, after reset.
   - char_xy=8'h00 → 7'h3E.
   - 8'h05 → 7'h53.
   - 8'h1F → 7'h30.
   - 8'h16 → 7'h31.
   - 8'h40 → 7'h20.
2. **Basic conversion:** scores {P1=123456, P2=0, P3=999}, one score_valid pulse.
   - busy is high for exactly 67 cycles.
   - 8'h1A..8'h1F then return 7'h31..7'h36.
   - 8'h2A..8'h2F return all 7'h30.
   - 8'h3A..8'h3F return 30,30,30,39,39,39.
3. **Saturation:** P1=1048575 → 8'h1A..8'h1F all return 7'h39. P2 converts normally in the same run.
4. **Ignored request:** a second score_valid with P1=42 issued at busy cycle 10 has no effect. The display still shows the first values, and busy stays 67 cycles.
5. **Reset mid-conversion:** rst asserted at busy cycle 30 → busy=0 and char_code=7'h20 asynchronously. Lookups of 8'h1F after release return 7'h30.
6. **Leading-zero blanking:** LZ_BLANK=1, P1=7 → 8'h1A..8'h1E return 7'h20 and 8'h1F returns 7'h37. P2=0 → 8'h2F returns 7'h30.
